// File: rtl/des_round_if.sv
// Handshake and datapath bundle between the DES round sequencer and its
// environment (block source, external f-function, result consumer).
interface des_round_if;
   logic        start_i;
   logic        ready_o;
   logic [1:64] block_i;
   logic        decrypt_i;
   logic [1:32] r_o;
   logic [4:0]  round_o;
   logic [1:32] f_i;
   logic        valid_o;
   logic        ack_i;
   logic [1:64] block_o;

   // Load side: start_i is taken only on a cycle with ready_o=1.
   // Result side: block_o is held with valid_o=1 until a cycle with ack_i=1.
   modport slave (
      input  start_i, block_i, decrypt_i, f_i, ack_i,
      output ready_o, r_o, round_o, valid_o, block_o
   );

   modport master (
      output start_i, block_i, decrypt_i, f_i, ack_i,
      input  ready_o, r_o, round_o, valid_o, block_o
   );
endinterface

// File: rtl/des_round_core.sv
// Iterative DES Feistel round sequencer: one round per clock, with the
// f-function computed outside from r_o/round_o and returned on f_i.
module des_round_core #(
   parameter int ROUNDS = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   des_round_if.slave  bus,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [4:0] LAST_RND = 5'(ROUNDS);
   localparam logic [5:0] RND_P1   = 6'(ROUNDS + 1);

   state_e      state_q, state_d;
   logic [1:32] l_q, l_d;
   logic [1:32] r_q, r_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        mode_q, mode_d;
   logic [5:0]  dec_idx;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         l_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      l_d     = l_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               l_d     = bus.block_i[1:32];
               r_d     = bus.block_i[33:64];
               cnt_d   = 5'd1;
               mode_d  = bus.decrypt_i;
               state_d = RUN;
            end
         end
         RUN: begin
            // f_i only reaches the registers here, so its value elsewhere is don't-care.
            l_d   = r_q;
            r_d   = l_q ^ bus.f_i;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_RND) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // A start arriving with the ack is dropped; it must be re-presented in IDLE.
            if (bus.ack_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Decrypt walks the key schedule backwards: ROUNDS, ROUNDS-1, ..., 1.
   assign dec_idx = RND_P1 - {1'b0, cnt_q};

   always_comb begin
      bus.round_o = 5'd0;
      if (state_q == RUN) begin
         bus.round_o = mode_q ? dec_idx[4:0] : cnt_q;
      end
   end

   assign bus.ready_o = (state_q == IDLE);
   assign bus.valid_o = (state_q == DONE);
   assign bus.r_o     = r_q;
   assign bus.block_o = (state_q == DONE) ? {r_q, l_q} : 64'd0;
   assign state_o     = state_q;

endmodule

// File: doc/des_round_core.md
DES_ROUND_CORE -- requirements
Module: des_round_core

Interface
REQ-001 Parameter: ROUNDS, default 16, meaning number of Feistel rounds per block (legal range 1..31).
REQ-002 Port: clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_ni  input  1  reset, synchronous, active-low.
REQ-004 Port: start_i  input  1  request to load a new block; accepted only when ready_o=1.
REQ-005 Port: ready_o  output  1  high in IDLE only.
REQ-006 Port: block_i  input  [1:64]  post-IP block, bit 1 = DES bit 1; [1:32]=L0, [33:64]=R0.
REQ-007 Port: decrypt_i  input  1  mode, sampled with start_i; 1=decrypt.
REQ-008 Port: r_o  output  [1:32]  current R register, driven directly from the flop, feeds the E expansion stage.
REQ-009 Port: round_o  output  5  subkey index for the key schedule; 0 outside RUN.
REQ-010 Port: f_i  input  [1:32]  f-function result for the current r_o and round_o, combinational, same cycle.
REQ-011 Port: valid_o  output  1  block_o holds a finished result.
REQ-012 Port: ack_i  input  1  consumer accepts block_o.
REQ-013 Port: block_o  output  [1:64]  pre-output R16||L16 (swapped), zero when valid_o=0.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; registers L[1:32], R[1:32], 5-bit round counter cnt, latched mode bit.
REQ-015 IDLE: ready_o=1; on start_i=1: L<=block_i[1:32], R<=block_i[33:64], cnt<=1, mode<=decrypt_i, go to RUN.
REQ-016 IDLE with start_i=0: all registers hold.
REQ-017 RUN, every cycle: L<=R, R<=L xor f_i, cnt<=cnt+1.
REQ-018 RUN to DONE on the edge where cnt=ROUNDS; RUN lasts exactly ROUNDS cycles.
REQ-019 round_o in RUN: cnt if mode=0; ROUNDS+1-cnt if mode=1; round_o=0 in IDLE and DONE.
REQ-020 DONE: valid_o=1, block_o=R||L; L, R held until ack_i.
REQ-021 DONE with ack_i=1: go to IDLE next edge; valid_o low from that cycle on.
REQ-022 Latency: start accepted at edge t gives valid_o=1 in the cycle after edge t+ROUNDS, i.e. ROUNDS+1 cycles after start; back-to-back throughput is one block per ROUNDS+2 cycles minimum.
REQ-023 start_i in RUN or DONE SHALL be ignored (no queuing); ack_i outside DONE SHALL be ignored.
REQ-024 start_i and ack_i together in DONE: only ack is acted on; the new start is taken only once in IDLE.
REQ-025 f_i SHALL be sampled only in RUN; its value in other states has no effect.

Reset
REQ-026 rst_ni=0 at a rising edge: state<=IDLE, L, R, cnt, mode<=0; so ready_o=1, valid_o=0, r_o=0, round_o=0, block_o=0.
REQ-027 Reset mid-RUN or in DONE SHALL abort the block; no valid_o is produced for it.
REQ-028 Reset has priority over start_i and ack_i in the same cycle.

Verification
REQ-029 f_i tied 0, block_i=0x0123456789ABCDEF, encrypt, ack_i=1 -> valid_o 17 cycles after start, block_o=0x89ABCDEF01234567, then ready_o=1.
REQ-030 f_i=0xFFFFFFFF only when round_o=1, else 0, same block_i -> block_o=0x89ABCDEFFEDCBA98.
REQ-031 decrypt_i=1 -> round_o sequence 16,15,...,1 over the 16 RUN cycles; encrypt gives 1..16; r_o equals the R register each cycle.
REQ-032 ack_i held 0 for 10 cycles in DONE -> valid_o and block_o stable; start_i pulses in RUN/DONE ignored; ack in the same cycle as start -> IDLE first.
REQ-033 rst_ni=0 at RUN cycle 5 -> next cycle ready_o=1, round_o=0, r_o=0, no valid_o; a fresh start then completes normally.
REQ-034 FIPS 46 known answer with the real E/S/P/key-schedule path attached: key 0x133457799BBCDFF1, IP(0x0123456789ABCDEF) -> FP(block_o)=0x85E813540F0AB405.
